// File: rtl/serie_paralelo_verde_pkg.sv
// Shared constants for the green-lane serial link: symbol width, comma value
// and receiver state encodings, common to both ends of the link.
package serie_paralelo_verde_pkg;

  localparam int unsigned VERDE_WIDTH = 8;
  localparam logic [7:0]  VERDE_COMMA = 8'hBC;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } verde_state_e;

endpackage

// File: rtl/serie_paralelo_verde_serial_shift_reg.sv
// MSB-first shift-in register; nb_o is the symbol completed at the current edge,
// i.e. the stored history with the incoming bit appended.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] nb_o
);

  // The oldest bit falls off when nb is formed, so only WIDTH-1 bits of history are kept.
  logic [WIDTH-2:0] sr_q;

  assign nb_o = {sr_q, bit_i};

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= nb_o[WIDTH-2:0];
    end
  end

endmodule

// File: rtl/serie_paralelo_verde.sv
// Green-lane serial-to-parallel receiver: hunts for comma alignment, locks after
// COMMA_COUNT aligned commas, then strobes out every non-comma symbol.
module serie_paralelo_verde
  import serie_paralelo_verde_pkg::*;
#(
  parameter int unsigned     WIDTH       = VERDE_WIDTH,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(VERDE_COMMA),
  parameter int unsigned     COMMA_COUNT = 4
) (
  input  logic             clk32_f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  verde_state_e     state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [CW-1:0]    bit_cnt_d;
  logic [3:0]       bc_cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             active_q;
  logic [WIDTH-1:0] nb;
  logic             boundary;
  logic             is_comma;

  serial_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk_i  (clk32_f),
    .srst_i (reset),
    .bit_i  (data_in),
    .nb_o   (nb)
  );

  assign boundary  = (bit_cnt_q == CW'(WIDTH - 1));
  assign is_comma  = (nb == COMMA);
  assign bit_cnt_d = boundary ? '0 : CW'(bit_cnt_q + 1'b1);

  always_ff @(posedge clk32_f) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      bit_cnt_q <= bit_cnt_d;
      unique case (state_q)
        ST_HUNT: begin
          // Any bit position may start a symbol; a match restarts the bit counter.
          if (is_comma) begin
            bit_cnt_q <= '0;
            bc_cnt_q  <= 4'd1;
            if (COMMA_COUNT == 1) begin
              state_q  <= ST_ACTIVE;
              active_q <= 1'b1;
            end else begin
              state_q <= ST_SYNC;
            end
          end
        end
        ST_SYNC: begin
          if (boundary) begin
            if (is_comma) begin
              bc_cnt_q <= bc_cnt_q + 4'd1;
              if ((bc_cnt_q + 4'd1) == 4'(COMMA_COUNT)) begin
                state_q  <= ST_ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              bc_cnt_q <= '0;
              state_q  <= ST_HUNT;
            end
          end
        end
        ST_ACTIVE: begin
          // Alignment is frozen here; commas are idle fill and never reach data_out.
          if (boundary && !is_comma) begin
            data_q  <= nb;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serie_paralelo_verde.sv
// Directed bench for the green-lane receiver: streams hand-built symbols and
// checks lock timing, strobes and held data on every bit edge.
module tb_serie_paralelo_verde;

  logic       clk32_f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int checks = 0;
  int errors = 0;

  // Expected values carried between symbols: data_out/active hold until a boundary.
  logic [7:0] last_data = 8'h00;
  logic       last_act  = 1'b0;

  serie_paralelo_verde dut (
    .clk32_f   (clk32_f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  always #5 clk32_f = ~clk32_f;

  task automatic drive_bit(input logic b);
    data_in = b;
    @(posedge clk32_f);
    #1;
  endtask

  // Drives one bit outside any symbol and checks that nothing is strobed or changed.
  task automatic quiet_bit(input logic b, input string tag);
    drive_bit(b);
    checks++;
    if (valid_out !== 1'b0 || data_out !== last_data || active !== last_act) begin
      errors++;
      $display("FAIL %s quiet bit: valid=%b data=%h active=%b required valid=0 data=%h active=%b",
               tag, valid_out, data_out, active, last_data, last_act);
    end
  endtask

  task automatic send_sym(input logic [7:0] s, input logic exp_v, input logic [7:0] exp_d,
                          input logic exp_act, input string tag);
    for (int i = 7; i >= 0; i--) begin
      drive_bit(s[i]);
      if (i != 0) begin
        checks++;
        if (valid_out !== 1'b0 || data_out !== last_data || active !== last_act) begin
          errors++;
          $display("FAIL %s bit%0d: valid=%b data=%h active=%b required valid=0 data=%h active=%b",
                   tag, 7 - i, valid_out, data_out, active, last_data, last_act);
        end
      end else begin
        checks++;
        if (valid_out !== exp_v) begin
          errors++;
          $display("FAIL %s valid: got %b required %b", tag, valid_out, exp_v);
        end
        checks++;
        if (data_out !== exp_d) begin
          errors++;
          $display("FAIL %s data: got %h required %h", tag, data_out, exp_d);
        end
        checks++;
        if (active !== exp_act) begin
          errors++;
          $display("FAIL %s active: got %b required %b", tag, active, exp_act);
        end
      end
    end
    last_data = exp_d;
    last_act  = exp_act;
    $display("sym %s %h -> valid=%b data=%h active=%b", tag, s, valid_out, data_out, active);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive_bit(1'b0);
      checks++;
      if (valid_out !== 1'b0 || data_out !== 8'h00 || active !== 1'b0) begin
        errors++;
        $display("FAIL reset cycle%0d: valid=%b data=%h active=%b required 0/00/0",
                 i, valid_out, data_out, active);
      end
    end
    reset     = 1'b0;
    last_data = 8'h00;
    last_act  = 1'b0;
  endtask

  task automatic lock_up(input string tag);
    for (int k = 0; k < 3; k++) send_sym(8'hBC, 1'b0, last_data, 1'b0, tag);
    send_sym(8'hBC, 1'b0, last_data, 1'b1, tag);
  endtask

  task automatic test_reset;
    apply_reset(3);
    for (int i = 0; i < 20; i++) quiet_bit(1'b0, "zeros");
    $display("test_reset done");
  endtask

  task automatic test_lock_and_data;
    apply_reset(1);
    send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t2_bc1");
    send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t2_bc2");
    send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t2_bc3");
    send_sym(8'hBC, 1'b0, 8'h00, 1'b1, "t2_bc4");
    send_sym(8'hA5, 1'b1, 8'hA5, 1'b1, "t2_a5");
    send_sym(8'h3C, 1'b1, 8'h3C, 1'b1, "t2_3c");
    send_sym(8'hBC, 1'b0, 8'h3C, 1'b1, "t2_idle");
  endtask

  task automatic test_misaligned;
    apply_reset(1);
    quiet_bit(1'b1, "t3_pre");
    quiet_bit(1'b0, "t3_pre");
    quiet_bit(1'b1, "t3_pre");
    lock_up("t3_bc");
    send_sym(8'h7E, 1'b1, 8'h7E, 1'b1, "t3_7e");
  endtask

  task automatic test_broken_sync;
    apply_reset(1);
    send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t4_bc1");
    send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t4_bc2");
    send_sym(8'h11, 1'b0, 8'h00, 1'b0, "t4_11");
    lock_up("t4_bc");
    send_sym(8'h22, 1'b1, 8'h22, 1'b1, "t4_22");
  endtask

  task automatic test_comma_between_data;
    apply_reset(1);
    lock_up("t5_bc");
    send_sym(8'h01, 1'b1, 8'h01, 1'b1, "t5_01");
    send_sym(8'hBC, 1'b0, 8'h01, 1'b1, "t5_idle");
    send_sym(8'h02, 1'b1, 8'h02, 1'b1, "t5_02");
  endtask

  task automatic test_reset_mid_symbol;
    apply_reset(1);
    lock_up("t6_bc");
    send_sym(8'h5A, 1'b1, 8'h5A, 1'b1, "t6_5a");
    quiet_bit(1'b1, "t6_part");
    quiet_bit(1'b1, "t6_part");
    quiet_bit(1'b0, "t6_part");
    apply_reset(1);
    send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t6_bc1");
    send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t6_bc2");
    send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t6_bc3");
    send_sym(8'hBC, 1'b0, 8'h00, 1'b1, "t6_bc4");
    send_sym(8'h55, 1'b1, 8'h55, 1'b1, "t6_55");
  endtask

  // Reset arriving on the very edge that completes a data symbol must suppress it.
  task automatic test_reset_on_boundary;
    logic [7:0] s;
    apply_reset(1);
    lock_up("t7_bc");
    send_sym(8'h5A, 1'b1, 8'h5A, 1'b1, "t7_5a");
    s = 8'h99;
    for (int i = 7; i >= 1; i--) quiet_bit(s[i], "t7_part");
    apply_reset(1);
    send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t7_after");
    $display("test_reset_on_boundary done");
  endtask

  initial begin
    test_reset();
    test_lock_and_data();
    test_misaligned();
    test_broken_sync();
    test_comma_between_data();
    test_reset_mid_symbol();
    test_reset_on_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
